phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 8, number of control steps T0..T(NUM_STEPS-1), legal range 2..16.
REQ-002 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 Parameter WAIT_MAX, default 15, maximum memory wait cycles before fault (used only with timeout compiled in).
REQ-004 Clock  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 Start  in  1  level; requests leave of IDLE.
REQ-007 Stop  in  1  level; requests halt at next instruction boundary.
REQ-008 StepLast  in  1  from decoder; current step is final step of this instruction.
REQ-009 MemStep  in  1  from decoder; current step performs Read or Write.
REQ-010 MemBusy  in  1  memory not ready; holds a memory step.
REQ-011 Step  out  NUM_STEPS  registered one-hot active control step.
REQ-012 StepIdx  out  $clog2(NUM_STEPS)  registered binary index of active step.
REQ-013 Run  out  1  high in RUN or WAIT.
REQ-014 Clear  out  1  one-cycle pulse when step wraps to T0 (instruction retired).
REQ-015 InstrCount  out  CNT_W  retired-instruction count.
REQ-016 Fault  out  1  sticky memory-timeout flag.

Function
REQ-017 States SHALL be IDLE, RUN, WAIT, FAULT.
REQ-018 IDLE: Step=0, StepIdx=0, Run=0; Start=1 and Stop=0 -> RUN with Step[0]=1 at next edge; Start and Stop both high -> remain IDLE.
REQ-019 RUN, MemStep=1 and MemBusy=1 -> WAIT, StepIdx held, Step held.
REQ-020 RUN otherwise: StepLast=1 or StepIdx=NUM_STEPS-1 -> StepIdx=0, Clear=1, InstrCount+1; else StepIdx+1.
REQ-021 WAIT: MemBusy=0 -> RUN with same advance rule as REQ-020 applied in that cycle; MemBusy=1 -> stay.
REQ-022 Stop sampled high in RUN or WAIT sets a pending flag; at the wrap to T0 with pending set -> IDLE, Clear still pulses, InstrCount still increments, pending cleared.
REQ-023 Stop never truncates an instruction mid-sequence.
REQ-024 InstrCount wraps modulo 2^CNT_W with no flag.
REQ-025 Step SHALL always equal one-hot(StepIdx) in RUN/WAIT and all-zero in IDLE/FAULT.
REQ-026 FAULT: Run=0, Step=0, Fault=1; left only by Reset.

Reset
REQ-027 Reset low SHALL immediately force IDLE, StepIdx=0, Step=0, Run=0, Clear=0, InstrCount=0, Fault=0, stop-pending=0, wait counter=0, including mid-WAIT.
REQ-028 First state change after Reset release SHALL occur on a rising Clock edge.

Configuration
REQ-029 Macro PHASE_SEQ_TIMEOUT_EN defined: a wait counter increments per WAIT cycle, clears on leaving WAIT; reaching WAIT_MAX with MemBusy still high -> FAULT.
REQ-030 Macro undefined: no wait counter, WAIT unbounded, Fault tied 0, FAULT unreachable.

Structure
REQ-031 Shared package seq_pkg SHALL hold the state encoding constants and default NUM_STEPS/CNT_W/WAIT_MAX.
REQ-032 Wait counter and timeout compare SHALL be sub-module wait_watchdog, instantiated only under PHASE_SEQ_TIMEOUT_EN.

Verification
REQ-033 Reset, Start=1 one cycle, StepLast at T4 -> Step 01,02,04,08,10 then 01; Clear one pulse; InstrCount=1.
REQ-034 No StepLast, NUM_STEPS=8 -> wrap after T7 to T0, Clear pulse, InstrCount increments.
REQ-035 MemStep=1 at T1, MemBusy high 3 cycles -> StepIdx=1 for 4 cycles, then T2.
REQ-036 Stop pulsed at T2 of 5-step instruction -> continues to T4, Clear pulse, IDLE, Run=0, Step=0; Start+Stop together in IDLE -> stays IDLE.
REQ-037 With PHASE_SEQ_TIMEOUT_EN, WAIT_MAX=15, MemBusy held -> FAULT after 15 WAIT cycles, Fault=1; Start ignored; Reset clears.
REQ-038 Reset asserted mid-WAIT, CNT_W=4 after 16 instructions -> outputs zero immediately; InstrCount wraps 15->0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings and default sizing for the phase sequencer and its watchdog.
package seq_pkg;

    localparam int DEF_NUM_STEPS = 8;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_WAIT_MAX  = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FAULT = 2'd3
    } SeqState;

endpackage

// File: rtl/phase_sequencer_wait_watchdog.sv
// Memory-wait watchdog: counts consecutive WAIT cycles and flags when the limit is hit.
module wait_watchdog #(
    parameter int WAIT_MAX = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic inWait,
    input  logic memBusy,
    output logic expired
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX - 1);
    localparam logic [CW-1:0] SATURATE = CW'(WAIT_MAX);

    logic [CW-1:0] waitCount;

    // One count per WAIT cycle; any cycle outside WAIT restarts the window.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            waitCount <= '0;
        end else if (!inWait) begin
            waitCount <= '0;
        end else if (waitCount != SATURATE) begin
            waitCount <= waitCount + CW'(1);
        end
    end

    // The current WAIT cycle is the WAIT_MAX-th one and memory is still busy.
    assign expired = inWait && memBusy && (waitCount == LIMIT);

endmodule

// File: rtl/phase_sequencer.sv
// Control-step sequencer T0..T(NUM_STEPS-1) with memory wait, stop-at-boundary and retire count.
// Optional memory-wait timeout is compiled in with PHASE_SEQ_TIMEOUT_EN.
module phase_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WAIT_MAX  = DEF_WAIT_MAX
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         Stop,
    input  logic                         StepLast,
    input  logic                         MemStep,
    input  logic                         MemBusy,
    output logic [NUM_STEPS-1:0]         Step,
    output logic [$clog2(NUM_STEPS)-1:0] StepIdx,
    output logic                         Run,
    output logic                         Clear,
    output logic [CNT_W-1:0]             InstrCount,
    output logic                         Fault
);

    localparam int IDX_W = $clog2(NUM_STEPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

    SeqState              state;
    SeqState              stateNext;
    logic [IDX_W-1:0]     idxNext;
    logic [NUM_STEPS-1:0] stepNext;
    logic                 stopPending;
    logic                 pendNext;
    logic                 wrap;
    logic                 timeout;

`ifdef PHASE_SEQ_TIMEOUT_EN
    wait_watchdog #(
        .WAIT_MAX (WAIT_MAX)
    ) uWatchdog (
        .Clock   (Clock),
        .Reset   (Reset),
        .inWait  (state == ST_WAIT),
        .memBusy (MemBusy),
        .expired (timeout)
    );

    assign Fault = (state == ST_FAULT);
`else
    logic unusedWaitMax;

    assign unusedWaitMax = (WAIT_MAX != 0);
    assign timeout       = 1'b0;
    assign Fault         = 1'b0;
`endif

    // Next state, next step index and retire pulse; a stop request only takes effect at a wrap.
    always_comb begin
        stateNext = state;
        idxNext   = StepIdx;
        pendNext  = stopPending;
        wrap      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                idxNext = '0;
                if (Start && !Stop) begin
                    stateNext = ST_RUN;
                end
            end
            ST_RUN, ST_WAIT: begin
                if (Stop) begin
                    pendNext = 1'b1;
                end
                if (state == ST_WAIT && timeout) begin
                    stateNext = ST_FAULT;
                    idxNext   = '0;
                    pendNext  = 1'b0;
                end else if (state == ST_WAIT ? MemBusy : (MemStep && MemBusy)) begin
                    stateNext = ST_WAIT;
                end else if (StepLast || StepIdx == LAST_IDX) begin
                    idxNext = '0;
                    wrap    = 1'b1;
                    if (stopPending || Stop) begin
                        stateNext = ST_IDLE;
                        pendNext  = 1'b0;
                    end else begin
                        stateNext = ST_RUN;
                    end
                end else begin
                    idxNext   = StepIdx + IDX_W'(1);
                    stateNext = ST_RUN;
                end
            end
            default: begin
                idxNext  = '0;
                pendNext = 1'b0;
            end
        endcase
    end

    // One-hot view of the next index, blanked whenever the sequencer is not stepping.
    always_comb begin
        stepNext = '0;
        if (stateNext == ST_RUN || stateNext == ST_WAIT) begin
            stepNext[idxNext] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            StepIdx     <= '0;
            Step        <= '0;
            stopPending <= 1'b0;
            Clear       <= 1'b0;
            InstrCount  <= '0;
        end else begin
            state       <= stateNext;
            StepIdx     <= idxNext;
            Step        <= stepNext;
            stopPending <= pendNext;
            Clear       <= wrap;
            if (wrap) begin
                InstrCount <= InstrCount + CNT_W'(1);
            end
        end
    end

    assign Run = (state == ST_RUN) || (state == ST_WAIT);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer (NUM_STEPS=8, CNT_W=4, WAIT_MAX=15).
module tb_phase_sequencer;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Stop;
    logic       StepLast;
    logic       MemStep;
    logic       MemBusy;
    logic [7:0] Step;
    logic [2:0] StepIdx;
    logic       Run;
    logic       Clear;
    logic [3:0] InstrCount;
    logic       Fault;

    int vectors = 0;
    int miscompares = 0;

    phase_sequencer #(
        .NUM_STEPS (8),
        .CNT_W     (4),
        .WAIT_MAX  (15)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Stop       (Stop),
        .StepLast   (StepLast),
        .MemStep    (MemStep),
        .MemBusy    (MemBusy),
        .Step       (Step),
        .StepIdx    (StepIdx),
        .Run        (Run),
        .Clear      (Clear),
        .InstrCount (InstrCount),
        .Fault      (Fault)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic stepLast,
                                 input logic memStep, input logic memBusy);
        Start    = start;
        Stop     = stop;
        StepLast = stepLast;
        MemStep  = memStep;
        MemBusy  = memBusy;
        @(posedge Clock);
        #1;
    endtask

    logic [7:0] expSteps [5];

    initial begin
        Reset = 1'b0;
        Start = 1'b0; Stop = 1'b0; StepLast = 1'b0; MemStep = 1'b0; MemBusy = 1'b0;
        #12;
        checkOutput("rstStep", Step, 8'h00);
        checkOutput("rstIdx", StepIdx, 3'd0);
        checkOutput("rstRun", Run, 1'b0);
        checkOutput("rstClear", Clear, 1'b0);
        checkOutput("rstCount", InstrCount, 4'd0);
        checkOutput("rstFault", Fault, 1'b0);
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idleHold", Run, 1'b0);

        // Five-step instruction ending with StepLast at T4.
        expSteps = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("i1Step0", Step, expSteps[0]);
        checkOutput("i1Run", Run, 1'b1);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("i1Step%0d", i), Step, expSteps[i]);
            checkOutput($sformatf("i1Clr%0d", i), Clear, 1'b0);
        end
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("i1Wrap", Step, 8'h01);
        checkOutput("i1Clear", Clear, 1'b1);
        checkOutput("i1Count", InstrCount, 4'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("i2T1", Step, 8'h02);
        checkOutput("i2ClrLow", Clear, 1'b0);

        // No StepLast: runs T1..T7 then wraps on its own.
        for (int i = 2; i < 8; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("i2T7Step", Step, 8'h80);
        checkOutput("i2T7Idx", StepIdx, 3'd7);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("i2Wrap", Step, 8'h01);
        checkOutput("i2Clear", Clear, 1'b1);
        checkOutput("i2Count", InstrCount, 4'd2);

        // Memory step at T1 busy for 3 cycles.
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("memT1", StepIdx, 3'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 1);
            checkOutput($sformatf("memHold%0d", i), StepIdx, 3'd1);
            checkOutput($sformatf("memStepHold%0d", i), Step, 8'h02);
            checkOutput($sformatf("memRun%0d", i), Run, 1'b1);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("memRelease", StepIdx, 3'd2);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("i3Count", InstrCount, 4'd3);

        // Stop pulsed at T2 of a five-step instruction.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stopAtT2", StepIdx, 3'd2);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("stopT3", Step, 8'h08);
        checkOutput("stopT3Run", Run, 1'b1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stopT4", Step, 8'h10);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("stopIdleRun", Run, 1'b0);
        checkOutput("stopIdleStep", Step, 8'h00);
        checkOutput("stopClear", Clear, 1'b1);
        checkOutput("stopCount", InstrCount, 4'd4);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idleClrLow", Clear, 1'b0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("startStopRun", Run, 1'b0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("startStopStep", Step, 8'h00);

        // Single-step instructions to drive the 4-bit counter through its wrap.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 5; i < 16; i++) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("cnt15", InstrCount, 4'd15);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("cntWrap", InstrCount, 4'd0);
        checkOutput("cntWrapClr", Clear, 1'b1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("cnt1", InstrCount, 4'd1);

        // Reset asserted in the middle of a WAIT.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("preRstWait", Run, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("midRstStep", Step, 8'h00);
        checkOutput("midRstIdx", StepIdx, 3'd0);
        checkOutput("midRstRun", Run, 1'b0);
        checkOutput("midRstCount", InstrCount, 4'd0);
        checkOutput("midRstClear", Clear, 1'b0);
        #3;
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("postRstIdle", Run, 1'b0);

        // Long memory stall from T1.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("stallEnter", StepIdx, 3'd1);
`ifdef PHASE_SEQ_TIMEOUT_EN
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("toLastWait", Run, 1'b1);
        checkOutput("toNoFaultYet", Fault, 1'b0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("toFault", Fault, 1'b1);
        checkOutput("toRun", Run, 1'b0);
        checkOutput("toStep", Step, 8'h00);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("toStartIgnored", Run, 1'b0);
        checkOutput("toSticky", Fault, 1'b1);
        Reset = 1'b0;
        #1;
        checkOutput("toRstClears", Fault, 1'b0);
        Reset = 1'b1;
`else
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("stallRun", Run, 1'b1);
        checkOutput("stallIdx", StepIdx, 3'd1);
        checkOutput("stallNoFault", Fault, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("stallRelease", StepIdx, 3'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
